// File: rtl/pool_sequencer.sv
// Pooling-pass sequencer: streams a feature map from the input buffer into the pooler,
// absorbing pooler stalls, and writes every pooled result to the output buffer.
module pool_sequencer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAP_W   = 12,
    parameter int unsigned MAP_H   = 12,
    parameter int unsigned POOL    = 2,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              master_rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pool_rst,
    output logic              pool_ce,
    output logic [DATA_W-1:0] pool_data,
    input  logic              pause_inputs,
    input  logic              valid_op,
    input  logic [DATA_W-1:0] data_out,
    input  logic              end_op,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int unsigned NUM_IN  = MAP_W * MAP_H;
    localparam int unsigned NUM_OUT = (MAP_W / POOL) * (MAP_H / POOL);
    // One spare bit so a counter can hold the full count even when it equals 2**ADDR_W.
    localparam int unsigned CW = ADDR_W + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] IN_TOTAL  = CW'(NUM_IN);
    localparam logic [CW-1:0] IN_LAST   = CW'(NUM_IN - 1);
    localparam logic [CW-1:0] OUT_TOTAL = CW'(NUM_OUT);
    localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StFin} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]     rd_cnt_q, pres_cnt_q, out_cnt_q;
    logic [CW-1:0]     out_next;
    logic              inflight_q;
    logic              hold_valid_q;
    logic [DATA_W-1:0] hold_q;
    logic [WW-1:0]     wd_q, wd_d;
    logic              pass_ok_q;
    logic              take_out;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    assign take_out = valid_op && (state_q == StStream || state_q == StDrain);
    assign out_next = out_cnt_q + CW'(take_out);

    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StClear;
            end
            StClear: state_d = StStream;
            StStream: begin
                if (end_op) begin
                    state_d = StFin;
                end else if (pool_ce && pres_cnt_q == IN_LAST) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (end_op) begin
                    state_d = StFin;
                end else if (!take_out && wd_q == WD_LIMIT) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StClear) || (state_q == StStream) || (state_q == StDrain);
        done      = (state_q == StFin) && pass_ok_q;
        err       = (state_q == StFin) && !pass_ok_q;
        pool_rst  = (state_q == StClear);
        rd_en     = (state_q == StStream) && (rd_cnt_q < IN_TOTAL) && !pause_inputs;
        rd_addr   = rd_en ? rd_cnt_q[ADDR_W-1:0] : '0;
        // The held word and a fresh in-flight word never coexist: reads stop while paused.
        pool_ce   = (state_q == StStream) && !pause_inputs && (hold_valid_q || inflight_q);
        pool_data = pool_ce ? (hold_valid_q ? hold_q : rd_data) : '0;
        wr_en     = wr_en_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
    end

    always_comb begin
        wd_d = '0;
        if (take_out) begin
            wd_d = WW'(1);
        end else if (state_q == StDrain) begin
            wd_d = wd_q + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            rd_cnt_q     <= '0;
            pres_cnt_q   <= '0;
            out_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
            wd_q         <= '0;
            pass_ok_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            wd_q      <= wd_d;
            pass_ok_q <= (state_q == StDrain) && end_op && (out_next == OUT_TOTAL);
            wr_en_q   <= take_out;
            if (take_out) begin
                wr_addr_q <= out_cnt_q[ADDR_W-1:0];
                wr_data_q <= data_out;
            end
            if (state_q == StClear) begin
                rd_cnt_q     <= '0;
                pres_cnt_q   <= '0;
                out_cnt_q    <= '0;
                inflight_q   <= 1'b0;
                hold_valid_q <= 1'b0;
            end else begin
                rd_cnt_q   <= rd_cnt_q + CW'(rd_en);
                inflight_q <= rd_en;
                out_cnt_q  <= out_next;
                if (pool_ce) pres_cnt_q <= pres_cnt_q + CW'(1);
                if (state_q == StStream && inflight_q && pause_inputs) begin
                    hold_q       <= rd_data;
                    hold_valid_q <= 1'b1;
                end else if (pool_ce && hold_valid_q) begin
                    hold_valid_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_sequencer.sv
// Bench for pool_sequencer: plays input buffer and a max-pooling pooler, checks the word
// stream, the output writes and the done/err outcome of directed and randomized passes.
module tb_pool_sequencer;

    localparam int DATA_W  = 32;
    localparam int MAP_W   = 12;
    localparam int MAP_H   = 12;
    localparam int POOL    = 2;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 64;
    localparam int N       = MAP_W * MAP_H;
    localparam int PW      = MAP_W / POOL;
    localparam int M       = PW * (MAP_H / POOL);

    logic              clk, master_rst_n, start;
    logic              busy, done, err, rd_en, pool_rst, pool_ce, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] rd_data, pool_data, data_out, wr_data;
    logic              pause_inputs, valid_op, end_op;
    logic [86:0]       outs_w;

    pool_sequencer #(
        .DATA_W(DATA_W), .MAP_W(MAP_W), .MAP_H(MAP_H), .POOL(POOL),
        .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .master_rst_n(master_rst_n), .start(start), .busy(busy), .done(done),
        .err(err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .pool_rst(pool_rst),
        .pool_ce(pool_ce), .pool_data(pool_data), .pause_inputs(pause_inputs),
        .valid_op(valid_op), .data_out(data_out), .end_op(end_op), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    assign outs_w = {busy, done, err, rd_en, rd_addr, pool_rst, pool_ce, pool_data,
                     wr_en, wr_addr, wr_data};

    int n_cmp = 0, n_fail = 0;
    int cyc = 0;

    logic [DATA_W-1:0] mem     [0:255];
    logic [DATA_W-1:0] exp_out [0:M-1];
    logic [DATA_W-1:0] rx_buf  [0:N-1];
    logic [DATA_W-1:0] res_q[$];

    // Knobs: pause pattern (0 none, 1 every 5th cycle, 2 random) and pooler behaviour
    // (0 normal, 1 never ends, 2 ends after M-1 results, 3 ends while inputs still stream).
    int pause_mode = 0, pm_mode = 0;

    int pres_idx, wr_idx, rd_count, rd_after_end, done_cnt, err_cnt, clear_cnt;
    int first_ce_cyc, clear_cyc, last_valid_cyc, err_cyc;
    bit ended;
    int rx_cnt, emitted;
    bit end_sent;
    logic              nxt_valid = 1'b0, nxt_end = 1'b0;
    logic [DATA_W-1:0] nxt_data = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] window_max(input int r, input int c, input bit use_rx);
        logic [DATA_W-1:0] m, v;
        int idx;
        m = '0;
        for (int i = 0; i < POOL; i++) begin
            for (int j = 0; j < POOL; j++) begin
                idx = (r * POOL + i) * MAP_W + c * POOL + j;
                v = use_rx ? rx_buf[idx] : mem[idx];
                if (v > m) m = v;
            end
        end
        return m;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Inputs from the pooler side change just after the active edge.
    always @(posedge clk) begin
        #1;
        case (pause_mode)
            1:       pause_inputs = (cyc % 5 == 4);
            2:       pause_inputs = ($urandom_range(0, 3) == 0);
            default: pause_inputs = 1'b0;
        endcase
        valid_op = nxt_valid;
        data_out = nxt_valid ? nxt_data : $urandom;
        end_op   = nxt_end;
    end

    // Monitor plus behavioural pooler, both sampled mid-cycle.
    always @(negedge clk) begin
        if (master_rst_n) begin
            if (pool_rst) begin
                clear_cnt++;
                clear_cyc = cyc;
            end
            if (rd_en) begin
                rd_count++;
                if (ended) rd_after_end++;
            end
            if (pool_ce) begin
                if (first_ce_cyc < 0) first_ce_cyc = cyc;
                check("ce_under_pause", pause_inputs, 1'b0);
                if (pres_idx < N) check($sformatf("pool_data[%0d]", pres_idx), pool_data, mem[pres_idx]);
                pres_idx++;
            end
            if (wr_en) begin
                if (wr_idx < M) begin
                    check($sformatf("wr_addr[%0d]", wr_idx), wr_addr, wr_idx[ADDR_W-1:0]);
                    check($sformatf("wr_data[%0d]", wr_idx), wr_data, exp_out[wr_idx]);
                end
                wr_idx++;
            end
            if (valid_op) last_valid_cyc = cyc;
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (done || err) begin
                check("busy_in_fin", busy, 1'b0);
                ended = 1'b1;
            end

            if (pool_rst) begin
                rx_cnt = 0;
                res_q.delete();
                emitted = 0;
                end_sent = 1'b0;
            end
            if (pool_ce && rx_cnt < N) begin
                rx_buf[rx_cnt] = pool_data;
                rx_cnt++;
                if (rx_cnt % (POOL * MAP_W) == 0) begin
                    for (int c = 0; c < PW; c++)
                        res_q.push_back(window_max(rx_cnt / (POOL * MAP_W) - 1, c, 1'b1));
                end
            end
            nxt_valid = 1'b0;
            nxt_end   = 1'b0;
            if (res_q.size() > 0 && emitted < ((pm_mode == 2) ? M - 1 : M)) begin
                nxt_data  = res_q.pop_front();
                nxt_valid = 1'b1;
                emitted++;
                if (!end_sent && (pm_mode == 0 || pm_mode == 2)
                    && emitted == ((pm_mode == 2) ? M - 1 : M)) begin
                    nxt_end  = 1'b1;
                    end_sent = 1'b1;
                end
            end
            if (!end_sent && pm_mode == 3 && rx_cnt >= 50) begin
                nxt_end  = 1'b1;
                end_sent = 1'b1;
            end
        end else begin
            nxt_valid = 1'b0;
            nxt_end   = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_pass(input int data_mode, input int pmode, input int pooler);
        for (int i = 0; i < N; i++) mem[i] = (data_mode == 0) ? DATA_W'(i) : $urandom;
        for (int r = 0; r < MAP_H / POOL; r++)
            for (int c = 0; c < PW; c++) exp_out[r * PW + c] = window_max(r, c, 1'b0);
        pause_mode = pmode;
        pm_mode = pooler;
        pres_idx = 0; wr_idx = 0; rd_count = 0; rd_after_end = 0;
        done_cnt = 0; err_cnt = 0; clear_cnt = 0;
        first_ce_cyc = -1; clear_cyc = -1; last_valid_cyc = -1; err_cyc = -1;
        ended = 1'b0;
    endtask

    task automatic run_pass(input int data_mode, input int pmode, input int pooler,
                            input int hold, input bit mid_start);
        bit finished;
        begin_pass(data_mode, pmode, pooler);
        start = 1'b1;
        for (int i = 0; i < hold; i++) step();
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        finished = 1'b0;
        for (int i = 0; i < 3000 && !finished; i++) begin
            step();
            start = mid_start && (i == 40);
            if (done_cnt + err_cnt > 0) finished = 1'b1;
        end
        start = 1'b0;
        if (!finished) begin
            check("pass_completion", 1'b0, 1'b1);
            master_rst_n = 1'b0;
            step();
            master_rst_n = 1'b1;
        end
        repeat (10) step();
        check("busy_after_pass", busy, 1'b0);
        check("clear_pulses", clear_cnt, 1);
        check("rd_after_end", rd_after_end, 0);
        case (pooler)
            0: begin
                check("done_cnt", done_cnt, 1);
                check("err_cnt", err_cnt, 0);
                check("words_presented", pres_idx, N);
                check("reads_issued", rd_count, N);
                check("writes", wr_idx, M);
                if (pmode == 0) check("first_ce_latency", first_ce_cyc - clear_cyc, 2);
            end
            1: begin
                check("timeout_err", err_cnt, 1);
                check("timeout_no_done", done_cnt, 0);
                check("timeout_writes", wr_idx, M);
                check("timeout_delay", err_cyc - last_valid_cyc, TIMEOUT);
            end
            2: begin
                check("short_err", err_cnt, 1);
                check("short_no_done", done_cnt, 0);
                check("short_writes", wr_idx, M - 1);
            end
            default: begin
                check("early_err", err_cnt, 1);
                check("early_no_done", done_cnt, 0);
                check("early_reads_stopped", rd_count < N, 1'b1);
            end
        endcase
    endtask

    initial begin
        master_rst_n = 1'b0;
        start = 1'b0;
        pause_inputs = 1'b0;
        valid_op = 1'b0;
        end_op = 1'b0;
        data_out = '0;
        rd_data = '0;
        begin_pass(0, 0, 0);
        repeat (3) step();
        check("reset_outputs", outs_w, '0);
        master_rst_n = 1'b1;
        step();
        check("idle_outputs", outs_w, '0);

        // Abort a pass mid-stream with reset.
        begin_pass(0, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 500 && pres_idx < 30; i++) step();
        check("reached_mid_stream", pres_idx >= 30, 1'b1);
        master_rst_n = 1'b0;
        #1;
        check("async_reset_outputs", outs_w, '0);
        repeat (2) step();
        master_rst_n = 1'b1;
        repeat (6) step();
        check("abort_no_done", done_cnt, 0);
        check("abort_no_err", err_cnt, 0);
        check("abort_idle", busy, 1'b0);

        run_pass(0, 0, 0, 1, 1'b0);
        run_pass(1, 1, 0, 1, 1'b0);
        run_pass(1, 2, 0, 1, 1'b0);
        run_pass(1, 0, 1, 1, 1'b0);
        run_pass(1, 1, 2, 1, 1'b0);
        run_pass(1, 0, 3, 1, 1'b0);
        run_pass(1, 2, 0, 3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
